vm_agent_shim_regs: RTL

VM_AGENT_SHIM_REGS -- requirements
Module: vm_agent_shim_regs

---
 rtl/vm_agent_shim_regs.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/vm_agent_shim_regs.sv
// AXI4-Lite register shim: scratch registers, doorbell FIFO toward the VM agent, status and ID.
// Optional VM_AGENT_SHIM_REGS_WSTRB_EN: honour WSTRB on scratch writes; doorbell requires a full-word strobe.
module vm_agent_shim_regs #(
    parameter logic [31:0] ID_VALUE = 32'h564D_4153,
    parameter int          DB_DEPTH = 4
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [4:0]  S_AXI_AWADDR,
    input  logic [2:0]  S_AXI_AWPROT,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [4:0]  S_AXI_ARADDR,
    input  logic [2:0]  S_AXI_ARPROT,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY,
    output logic [31:0] DB_DATA,
    output logic        DB_VALID,
    input  logic        DB_READY
);
    localparam int AW = $clog2(DB_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {
        REG_SCR0, REG_SCR1, REG_SCR2, REG_SCR3, REG_DB, REG_STATUS, REG_ID, REG_UNMAP
    } reg_e;

    logic [31:0]   r_scratch [4];
    logic [31:0]   r_mem [DB_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_awready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]    r_bresp, r_rresp;
    logic [31:0]   r_rdata;

    reg_e          w_waddr, w_raddr;
    logic          w_wr_hs, w_rd_hs, w_full, w_empty, w_pop, w_push;
    logic          w_db_sel, w_strb_ok, w_db_drop;
    logic [1:0]    w_bresp, w_rresp;
    logic [31:0]   w_rdata;
    logic          w_unused;

    assign w_waddr  = reg_e'(S_AXI_AWADDR[4:2]);
    assign w_raddr  = reg_e'(S_AXI_ARADDR[4:2]);
    assign w_wr_hs  = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
    assign w_rd_hs  = r_arready & S_AXI_ARVALID;
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DB_DEPTH));
    assign w_pop    = ~w_empty & DB_READY;
    assign w_db_sel = w_wr_hs & (w_waddr == REG_DB);
`ifdef VM_AGENT_SHIM_REGS_WSTRB_EN
    assign w_strb_ok = (S_AXI_WSTRB == 4'hF);
`else
    assign w_strb_ok = 1'b1;
`endif
    // A pop on the same edge frees a slot, so a full FIFO still takes the push.
    assign w_db_drop = w_full & ~w_pop;
    assign w_push    = w_db_sel & w_strb_ok & ~w_db_drop;
    assign w_unused  = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_WSTRB};

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_awready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;
    assign DB_VALID      = ~w_empty;
    assign DB_DATA       = w_empty ? '0 : r_mem[r_rptr];

    always_comb begin
        w_bresp = OKAY;
        if (w_waddr == REG_UNMAP || (w_waddr == REG_DB && (!w_strb_ok || w_db_drop)))
            w_bresp = SLVERR;
    end

    always_comb begin
        w_rdata = '0;
        w_rresp = OKAY;
        case (w_raddr)
            REG_SCR0, REG_SCR1, REG_SCR2, REG_SCR3: w_rdata = r_scratch[w_raddr[1:0]];
            REG_STATUS: w_rdata = {r_ovf, 21'b0, w_full, w_empty, 3'b0, 5'(r_count)};
            REG_ID:     w_rdata = ID_VALUE;
            REG_UNMAP:  w_rresp = SLVERR;
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= OKAY;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= OKAY;
            r_rdata   <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) r_scratch[i] <= '0;
        end else begin
            r_awready <= S_AXI_AWVALID & S_AXI_WVALID & ~r_bvalid & ~r_awready;
            r_arready <= S_AXI_ARVALID & ~r_rvalid & ~r_arready;

            if (w_wr_hs) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_bresp;
                if (w_waddr inside {REG_SCR0, REG_SCR1, REG_SCR2, REG_SCR3}) begin
                    for (int unsigned b = 0; b < 4; b++) begin
`ifdef VM_AGENT_SHIM_REGS_WSTRB_EN
                        if (S_AXI_WSTRB[b])
`endif
                            r_scratch[w_waddr[1:0]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                    end
                end
                if (w_waddr == REG_STATUS && S_AXI_WDATA[31]) r_ovf <= 1'b0;
                if (w_db_sel && w_strb_ok && w_db_drop) r_ovf <= 1'b1;
            end else if (r_bvalid && S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end

            if (w_rd_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rdata;
                r_rresp  <= w_rresp;
            end else if (r_rvalid && S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end

            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_push) r_mem[r_wptr] <= S_AXI_WDATA;
    end
endmodule
